// File: rtl/pe_array_feeder.sv
// Diagonal skew feeder for pe_array: lane i delayed i cycles, compute strobe with flush tail, done pulse.
// Optional FEEDER_STALL_CNT_EN adds a saturating count of STREAM cycles with no valid input.
module pe_array_feeder #(
  parameter int unsigned ARRAY_SIZE         = 2,
  parameter int unsigned COMPUTE_DATA_WIDTH = 4,
  parameter int unsigned FLUSH_CYCLES       = 4
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 in_valid,
  output logic                                                 in_ready,
  input  logic signed [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] in_data,
  input  logic                                                 in_last,
  output logic signed [ARRAY_SIZE-1:0][COMPUTE_DATA_WIDTH-1:0] datas_out,
  output logic                                                 compute_out,
  output logic                                                 done,
  output logic                                                 busy
`ifdef FEEDER_STALL_CNT_EN
  ,
  output logic [15:0]                                          stall_count
`endif
);

  localparam int unsigned FLUSH_LEN = ARRAY_SIZE - 1 + FLUSH_CYCLES;
  localparam int unsigned CW        = (FLUSH_LEN > 0) ? $clog2(FLUSH_LEN + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_FLUSH,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          compute_q, compute_d;
  logic          accept;

  assign in_ready    = (state_q == S_IDLE) || (state_q == S_STREAM);
  assign accept      = in_valid && in_ready;
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign compute_out = compute_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      compute_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      compute_q <= compute_d;
    end
  end

  // FLUSH lasts FLUSH_LEN cycles; with FLUSH_LEN == 0 the pass goes straight to DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_STREAM: begin
        if (accept) begin
          if (in_last) begin
            if (FLUSH_LEN == 0) begin
              state_d = S_DONE;
            end else begin
              state_d = S_FLUSH;
              cnt_d   = CW'(FLUSH_LEN);
            end
          end else begin
            state_d = S_STREAM;
          end
        end
      end
      S_FLUSH: begin
        if (cnt_q <= CW'(1)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    compute_d = (state_d == S_STREAM) || (state_d == S_FLUSH);
  end

  // Chains shift every cycle; without a handshake a zero enters, so the flush tail drains them.
  for (genvar g = 0; g < ARRAY_SIZE; g++) begin : g_lane
    logic signed [COMPUTE_DATA_WIDTH-1:0] chain_q [g+1];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int unsigned k = 0; k <= g; k++) begin
          chain_q[k] <= '0;
        end
      end else begin
        chain_q[0] <= accept ? in_data[g] : '0;
        for (int unsigned k = 1; k <= g; k++) begin
          chain_q[k] <= chain_q[k-1];
        end
      end
    end

    assign datas_out[g] = compute_q ? chain_q[g] : '0;
  end

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else if ((state_q == S_IDLE) && accept) begin
      stall_q <= '0;
    end else if ((state_q == S_STREAM) && !in_valid && (stall_q != '1)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_count = stall_q;
`endif

endmodule
